// File: rtl/so3s_otfc_seq_pkg.sv
// Shared types for the on-the-fly conversion sequencer: signed-digit encoding,
// FSM state enum and a digit decode helper.
// No ports; imported by the interface, the step datapath and the sequencer top.
package so3s_otfc_seq_pkg;

  // Radix-2 signed digit, value = plus - minus; {1,1} carries value 0.
  typedef struct packed {
    logic plus;
    logic minus;
  } signed_digit;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_APPEND,
    ST_DONE
  } so3s_otfc_state_e;

  typedef enum logic [1:0] {
    DIG_ZERO,
    DIG_POS,
    DIG_NEG
  } digit_val_e;

  function automatic digit_val_e decode_digit(input signed_digit dig);
    digit_val_e v;
    v = DIG_ZERO;
    if (dig.plus && !dig.minus) v = DIG_POS;
    if (dig.minus && !dig.plus) v = DIG_NEG;
    return v;
  endfunction

endpackage

// File: rtl/so3s_otfc_seq_if.sv
// Bundle of the digit-input and result-output handshakes of the OTFC sequencer.
// Ports: start, d_valid/d/d_ready (digit stream), j, busy, res_valid/res_ready/q/qm (result).
// Build option SO3S_OTFC_ABORT_EN adds the abort request line.
interface so3s_otfc_seq_if #(
  parameter int X_WIDTH = 8,
  parameter int WIDTH   = 11
);
  import so3s_otfc_seq_pkg::*;

  logic                       start;
  logic                       d_valid;
  signed_digit                d;
  logic                       d_ready;
  logic [$clog2(X_WIDTH):0]   j;
  logic                       busy;
  logic                       res_valid;
  logic                       res_ready;
  logic [WIDTH-1:0]           q;
  logic [WIDTH-1:0]           qm;
`ifdef SO3S_OTFC_ABORT_EN
  logic                       abort;

  modport master (
    output start, d_valid, d, res_ready, abort,
    input  d_ready, j, busy, res_valid, q, qm
  );
  modport slave (
    input  start, d_valid, d, res_ready, abort,
    output d_ready, j, busy, res_valid, q, qm
  );
`else
  modport master (
    output start, d_valid, d, res_ready,
    input  d_ready, j, busy, res_valid, q, qm
  );
  modport slave (
    input  start, d_valid, d, res_ready,
    output d_ready, j, busy, res_valid, q, qm
  );
`endif

endinterface

// File: rtl/so3s_otfc_step.sv
// Single-digit OTFC update: selects the new q/qm pair from the old pair and bit p.
// Ports: q_i, qm_i, d_i, p_i in; q_next_o, qm_next_o out. Purely combinational, no backpressure.
// Bit p is known to be zero in both q and qm, so OR replaces any addition.
module so3s_otfc_step
  import so3s_otfc_seq_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int PW    = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] qm_i,
  input  signed_digit      d_i,
  input  logic [PW-1:0]    p_i,
  output logic [WIDTH-1:0] q_next_o,
  output logic [WIDTH-1:0] qm_next_o
);

  logic [WIDTH-1:0] bit_p;

  always_comb begin
    bit_p     = {{(WIDTH-1){1'b0}}, 1'b1} << p_i;
    q_next_o  = q_i;
    qm_next_o = qm_i | bit_p;
    unique case (decode_digit(d_i))
      DIG_POS: begin
        q_next_o  = q_i | bit_p;
        qm_next_o = q_i;
      end
      DIG_NEG: begin
        q_next_o  = qm_i | bit_p;
        qm_next_o = qm_i;
      end
      default: begin
        q_next_o  = q_i;
        qm_next_o = qm_i | bit_p;
      end
    endcase
  end

endmodule

// File: rtl/so3s_otfc_seq.sv
// OTFC sequencer: drops DELAY leading digits, appends X_WIDTH digits MSD first into q/qm.
// Ports: clk, rst (async active-high), bus (slave side of so3s_otfc_seq_if).
// Latency DELAY+X_WIDTH handshakes; d_valid low stalls; DONE holds until res_ready.
// Build option SO3S_OTFC_ABORT_EN: abort in DELAY/APPEND returns to IDLE with cleared q/qm/j.
module so3s_otfc_seq
  import so3s_otfc_seq_pkg::*;
#(
  parameter int X_WIDTH = 8,
  parameter int WIDTH   = 11,
  parameter int DELAY   = 3
) (
  input  logic             clk,
  input  logic             rst,
  so3s_otfc_seq_if.slave   bus
);

  localparam int JW = $clog2(X_WIDTH) + 1;
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

  localparam logic [JW-1:0] J_LAST = JW'(X_WIDTH - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DELAY - 1);
  // -(2^X_WIDTH): the "q minus one ulp" of an empty result at the top position.
  localparam logic [WIDTH-1:0] QM_INIT = {{(WIDTH-X_WIDTH){1'b1}}, {X_WIDTH{1'b0}}};

  so3s_otfc_state_e state_q, state_d;
  logic [JW-1:0]    j_q, j_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qm_q, qm_d;

  logic [PW-1:0]    p_idx;
  logic [WIDTH-1:0] q_step, qm_step;
  logic             in_run;

  // Position of the digit being appended: p = X_WIDTH - (j+1).
  assign p_idx = PW'(X_WIDTH - 1) - PW'(j_q);

  so3s_otfc_step #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_step (
    .q_i       (q_q),
    .qm_i      (qm_q),
    .d_i       (bus.d),
    .p_i       (p_idx),
    .q_next_o  (q_step),
    .qm_next_o (qm_step)
  );

  assign in_run = (state_q == ST_DELAY) || (state_q == ST_APPEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      dcnt_q  <= '0;
      q_q     <= '0;
      qm_q    <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      dcnt_q  <= dcnt_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    dcnt_d  = dcnt_q;
    q_d     = q_q;
    qm_d    = qm_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          j_d     = '0;
          dcnt_d  = '0;
          q_d     = '0;
          qm_d    = QM_INIT;
          state_d = (DELAY == 0) ? ST_APPEND : ST_DELAY;
        end
      end
      ST_DELAY: begin
        // d_ready is high here, so d_valid alone is the handshake.
        if (bus.d_valid) begin
          dcnt_d = dcnt_q + DW'(1);
          if (dcnt_q == D_LAST) state_d = ST_APPEND;
        end
      end
      ST_APPEND: begin
        if (bus.d_valid) begin
          q_d  = q_step;
          qm_d = qm_step;
          j_d  = j_q + JW'(1);
          if (j_q == J_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start arriving together with res_ready is deliberately dropped.
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef SO3S_OTFC_ABORT_EN
    // Abort wins over any digit accepted in the same cycle.
    if (bus.abort && in_run) begin
      state_d = ST_IDLE;
      j_d     = '0;
      dcnt_d  = '0;
      q_d     = '0;
      qm_d    = '0;
    end
`endif
  end

  assign bus.d_ready   = in_run;
  assign bus.busy      = in_run;
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.j         = j_q;
  assign bus.q         = q_q;
  assign bus.qm        = qm_q;

endmodule

// File: tb/tb_so3s_otfc_seq.sv
// Bench for so3s_otfc_seq: directed scenarios plus randomized digit streams.
// Expected q/qm come from the signed-digit sum; a negedge monitor pops and compares results.
module tb_so3s_otfc_seq;
  import so3s_otfc_seq_pkg::*;

  localparam int XW   = 8;
  localparam int W    = 11;
  localparam int DL   = 3;
  localparam int NDIG = DL + XW;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] qm;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  exp_t mon_e;
  logic [1:0] stim [NDIG];

  so3s_otfc_seq_if #(.X_WIDTH(XW), .WIDTH(W)) bus ();

  so3s_otfc_seq #(.X_WIDTH(XW), .WIDTH(W), .DELAY(DL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Result monitor: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("res_q", int'(bus.q), int'(mon_e.q));
        chk("res_qm", int'(bus.qm), int'(mon_e.qm));
        chk("res_j", int'(bus.j), XW);
      end
    end
  end

  function automatic int dval(input logic [1:0] x);
    return int'(x[1]) - int'(x[0]);
  endfunction

  // Stream kinds: 0 = zeros delay + (+1,0,...); 1 = zeros + all -1; 2 = +1 delay + zeros.
  task automatic set_stim(input int kind);
    for (int i = 0; i < NDIG; i++) stim[i] = 2'b00;
    if (kind == 0) stim[DL] = 2'b10;
    if (kind == 1) for (int i = DL; i < NDIG; i++) stim[i] = 2'b01;
    if (kind == 2) for (int i = 0; i < DL; i++) stim[i] = 2'b10;
    if (kind == 3) for (int i = 0; i < NDIG; i++) stim[i] = 2'($urandom_range(0, 3));
  endtask

  // vmode: 0 continuous, 1 valid every other cycle, 2 random valid.
  // kill_at >= 0: stop after that many appended digits via reset (kill_abort=0) or abort.
  task automatic run_conv(input int vmode, input int rr_wait, input bit pulse,
                          input int kill_at, input int kill_abort, input int exp_lat);
    exp_t e;
    int   val;
    int   idx;
    int   ph;
    int   guard;
    int   t0;
    int   t1;
    bit   hs;
    val = 0;
    for (int k = 1; k <= XW; k++) val += dval(stim[DL+k-1]) * (1 << (XW - k));
    e.q  = val[W-1:0];
    val  = val - 1;
    e.qm = val[W-1:0];
    if (kill_at < 0) sb.push_back(e);

    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t0 = cyc;
    idx = 0; ph = 0; guard = 0;
    while (idx < NDIG && guard < 400) begin
      bus.d = signed_digit'(stim[idx]);
      case (vmode)
        0:       bus.d_valid = 1'b1;
        1:       bus.d_valid = (ph % 2 == 0);
        default: bus.d_valid = 1'($urandom_range(0, 1));
      endcase
      ph++; guard++;
      @(negedge clk);
      hs = bus.d_valid && bus.d_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      chk("j_progress", int'(bus.j), (idx > DL) ? idx - DL : 0);
      if (kill_at >= 0 && idx == DL + kill_at) break;
    end
    bus.d_valid = 1'b0;
    if (idx < NDIG && kill_at < 0) begin
      chk("digit_timeout", idx, NDIG);
      return;
    end

    if (kill_at >= 0) begin
      if (kill_abort == 0) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_q", int'(bus.q), 0);
        chk("rst_qm", int'(bus.qm), 0);
        chk("rst_j", int'(bus.j), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_d_ready", int'(bus.d_ready), 0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
      end else begin
`ifdef SO3S_OTFC_ABORT_EN
        bus.abort   = 1'b1;
        bus.d_valid = 1'b1;
        bus.d       = signed_digit'(stim[idx]);
        @(posedge clk); #1;
        bus.abort   = 1'b0;
        bus.d_valid = 1'b0;
        chk("abort_q", int'(bus.q), 0);
        chk("abort_qm", int'(bus.qm), 0);
        chk("abort_j", int'(bus.j), 0);
        chk("abort_busy", int'(bus.busy), 0);
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_res", int'(bus.res_valid), 0);
        end
        @(posedge clk); #1;
`endif
      end
      return;
    end

    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.res_valid && guard < 50);
    chk("res_valid_seen", int'(bus.res_valid), 1);
    if (!bus.res_valid) return;
    t1 = cyc;
    if (exp_lat > 0) chk("latency", t1 - t0 + 1, exp_lat);

    @(posedge clk); #1;
    for (int h = 0; h < rr_wait; h++) begin
      bus.start   = pulse && (h % 2 == 0);
      bus.d_valid = pulse;
      @(negedge clk);
      chk("hold_q", int'(bus.q), int'(e.q));
      chk("hold_qm", int'(bus.qm), int'(e.qm));
      chk("hold_j", int'(bus.j), XW);
      chk("hold_res_valid", int'(bus.res_valid), 1);
      chk("hold_d_ready", int'(bus.d_ready), 0);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    bus.start     = pulse;
    bus.d_valid   = pulse;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    bus.d_valid   = 1'b0;
    @(negedge clk);
    chk("idle_res_valid", int'(bus.res_valid), 0);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_q_kept", int'(bus.q), int'(e.q));
    @(negedge clk);
    chk("start_dropped", int'(bus.busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst   = 1'b0;
    bus.start     = 1'b0;
    bus.d_valid   = 1'b0;
    bus.d         = '0;
    bus.res_ready = 1'b0;
`ifdef SO3S_OTFC_ABORT_EN
    bus.abort     = 1'b0;
`endif
    #1 rst = 1'b1;
    #2;
    chk("reset_q", int'(bus.q), 0);
    chk("reset_qm", int'(bus.qm), 0);
    chk("reset_j", int'(bus.j), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_d_ready", int'(bus.d_ready), 0);
    chk("reset_res_valid", int'(bus.res_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    set_stim(0); run_conv(0, 0, 1'b0, -1, 0, 12);   // +1 then zeros
    set_stim(1); run_conv(0, 0, 1'b0, -1, 0, 12);   // eight -1
    set_stim(2); run_conv(0, 0, 1'b0, -1, 0, 0);    // delay digits discarded
    set_stim(0); run_conv(1, 0, 1'b0, -1, 0, 22);   // valid every other cycle
    set_stim(0); run_conv(0, 5, 1'b1, -1, 0, 0);    // held result, start/d_valid pulsed
    set_stim(0); run_conv(0, 0, 1'b0, 5, 0, 0);     // async reset after 5th digit
    set_stim(0); run_conv(0, 0, 1'b0, -1, 0, 12);
`ifdef SO3S_OTFC_ABORT_EN
    set_stim(1); run_conv(0, 0, 1'b0, 5, 1, 0);     // abort after 5th digit
    set_stim(1); run_conv(0, 0, 1'b0, -1, 0, 12);
`endif
    for (int r = 0; r < 25; r++) begin
      set_stim(3);
      run_conv($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1, 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/so3s_otfc_seq.md
Name: so3s_otfc_seq

Overview:
- Sequencer and state holder for on-the-fly conversion (OTFC) of a radix-2 signed-digit stream, MSD first, into two's-complement Q/QM words.
- Accepts digits from an upstream online operator through a valid/ready handshake.
- Discards the first DELAY digits (online delay), appends X_WIDTH digits, then presents the result through a valid/ready handshake.
- Sits between the online arithmetic core and the conventional-result consumer.

Parameters:
- X_WIDTH, 8: number of result digits appended.
- WIDTH, 11: width of q/qm, two's complement; requires WIDTH >= X_WIDTH+2.
- DELAY, 3: online delay; number of leading accepted digits discarded (0 allowed).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a conversion; sampled only in IDLE.
- d_valid  in  1  digit valid.
- d  in  signed_digit (2)  digit {plus, minus}; value = plus - minus; {1,1} is treated as 0.
- d_ready  out  1  digit accepted when d_valid && d_ready.
- j  out  $clog2(X_WIDTH)+1  number of digits appended so far (0..X_WIDTH).
- busy  out  1  high in DELAY or APPEND.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- q  out  WIDTH  converted value, scaled by 2^X_WIDTH.
- qm  out  WIDTH  q minus one ulp of the current position.

Behaviour:
- Reset (async, rst=1): state=IDLE; q=0, qm=0, j=0, delay counter=0; d_ready=0, busy=0, res_valid=0.
- States: IDLE, DELAY, APPEND, DONE.
- IDLE:
  - On start=1: clear j and the delay counter; load q=0 and qm = -(2^X_WIDTH), sign-extended to WIDTH.
  - Next state is DELAY, or APPEND if DELAY=0.
- DELAY:
  - d_ready=1.
  - Each handshake increments the delay counter; the digit is discarded.
  - After the DELAY-th handshake, go to APPEND.
- APPEND:
  - d_ready=1.
  - On each handshake, with k = j+1 and p = X_WIDTH-k:
    - d=+1: q <= q | 2^p, qm <= q.
    - d=0: q <= q, qm <= qm | 2^p.
    - d=-1: q <= qm | 2^p, qm <= qm.
  - Then j <= k.
  - Pure OR/select logic; no adders. Bit p is guaranteed zero in both q and qm before the update.
  - Invariant after every step: qm == q - 2^p.
  - When k == X_WIDTH, go to DONE.
- DONE:
  - d_ready=0, res_valid=1.
  - q, qm and j are held stable while res_ready=0.
  - On res_ready=1, go to IDLE; res_valid drops the next cycle.
  - q/qm keep their final values in IDLE until the next start.
- Latency: DELAY+X_WIDTH digit handshakes, then res_valid in the cycle after the last handshake. With a continuous stream this is DELAY+X_WIDTH+1 cycles from start.
- d_valid=0 stalls the sequence; no state, counter or register changes.
- start outside IDLE is ignored. This includes a start in DONE coinciding with res_ready: that transition goes to IDLE and the start is dropped.
- d_valid while in IDLE or DONE: not accepted, ignored.
- rst mid-conversion: immediate return to reset values; the partial result is lost.
- Overflow is impossible by construction: |value| <= 2^X_WIDTH - 1.

Optional Feature:
- Macro SO3S_OTFC_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in DELAY or APPEND: next state is IDLE; q=0, qm=0, j=0; no res_valid; any concurrent digit handshake is discarded.
  - abort in IDLE or DONE is ignored.
- Undefined: the port is absent and a conversion always runs to DONE.

Decomposition:
- rbr_pkg: signed_digit (existing) and a new enum so3s_otfc_state_e {IDLE, DELAY, APPEND, DONE}.
- Sub-module so3s_otfc_step: combinational single-digit update (q, qm, d, p -> q_next, qm_next).
- so3s_otfc_seq holds the FSM, the counters and the q/qm registers.

Test Plan:
All scenarios use X_WIDTH=8, WIDTH=11, DELAY=3.
1. start; 3 delay digits 0; then +1 followed by seven 0s, continuous valid -> res_valid 12 cycles after start; q=0x080, qm=0x07F, j=8.
2. Delay digits 0; eight -1 digits -> q=0x701 (-255), qm=0x700 (-256).
3. Delay digits +1,+1,+1; eight 0 digits -> q=0x000, qm=0x7FF (delay digits discarded).
4. Same stream as 1 with d_valid toggled every other cycle -> j advances only on handshakes; identical final q/qm; res_valid after 22 cycles.
5. Hold res_ready=0 for 5 cycles in DONE while pulsing start and d_valid -> q/qm/res_valid stable, d_ready=0; res_ready=1 -> IDLE, start in that cycle dropped.
6. Assert rst asynchronously after the 5th appended digit -> q=0, qm=0, j=0, busy=0 with no clock edge required; the following full conversion is correct (with SO3S_OTFC_ABORT_EN, repeat using abort -> IDLE next cycle, no res_valid).
